// File: rtl/hd_result_packer_pkg.sv
// Shared widths and types for the kernel result packer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hd_pkg;

    localparam int HD_DATA_W = 8;
    localparam int HD_LANES  = 4;

    typedef logic [HD_DATA_W-1:0]          hd_word_t;
    typedef logic [$clog2(HD_LANES)-1:0]   hd_lane_idx_t;
    typedef logic [HD_DATA_W*HD_LANES-1:0] hd_packed_t;

endpackage

// File: rtl/hd_result_packer_if.sv
// Input result stream and packed output stream of the result packer.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both sides; the slave modport is the packer's view.
// Signals: in_valid/in_ready/in_data/in_last (kernel -> packer),
//          out_valid/out_ready/out_data/out_keep/out_last (packer -> consumer).
interface hd_result_packer_if import hd_pkg::*; #(
    parameter int DATA_W = HD_DATA_W,
    parameter int LANES  = HD_LANES
) ();

    logic                      in_valid;
    logic                      in_ready;
    logic [DATA_W-1:0]         in_data;
    logic                      in_last;
    logic                      out_valid;
    logic                      out_ready;
    logic [DATA_W*LANES-1:0]   out_data;
    logic [LANES-1:0]          out_keep;
    logic                      out_last;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_keep, out_last
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_keep, out_last
    );

endinterface

// File: rtl/hd_result_packer_out_reg.sv
// Output holding register: loads a word, drains it on ready, holds it otherwise.
// Latency: one cycle from load to valid.
// Backpressure: contents frozen while valid && !ready; a load in the drain cycle replaces the word.
// Ports: clk, rst, load/load_data/load_keep/load_last in; drain_ready in;
//        out_valid/out_data/out_keep/out_last out.
module hd_out_reg #(
    parameter int W = 32,
    parameter int K = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic [K-1:0] load_keep,
    input  logic         load_last,
    input  logic         drain_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic [K-1:0] out_keep,
    output logic         out_last
);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
            out_keep  <= load_keep;
            out_last  <= load_last;
        end else if (out_valid && drain_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/hd_result_packer.sv
// Packs LANES consecutive kernel results little-endian into one word with keep/last, counts words sent.
// Latency: one cycle from the closing input handshake to out_valid.
// Backpressure: in_ready = !out_valid || out_ready; assembly holds while the output is stalled.
// Ports: clk, rst (sync, active-high), bus (slave: input and output streams), words_sent.
module hd_result_packer import hd_pkg::*; #(
    parameter int DATA_W = HD_DATA_W,
    parameter int LANES  = HD_LANES,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    hd_result_packer_if.slave bus,
    output logic [CNT_W-1:0]  words_sent
);

    localparam int IDX_W = $clog2(LANES);

    logic [IDX_W-1:0]        idx;
    logic [DATA_W*LANES-1:0] asm_data;
    logic [LANES-1:0]        asm_keep;
    logic [DATA_W*LANES-1:0] word_d;
    logic [LANES-1:0]        keep_d;
    logic                    accept;
    logic                    close;

    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;
    assign close        = accept && ((idx == IDX_W'(LANES - 1)) || bus.in_last);

    // Assembly contents with the current result merged into lane idx; this is
    // both the next assembly state and, on close, the word handed to the output.
    always_comb begin
        word_d = asm_data;
        keep_d = asm_keep;
        for (int k = 0; k < LANES; k++) begin
            if (idx == IDX_W'(k)) begin
                word_d[k*DATA_W +: DATA_W] = bus.in_data;
                keep_d[k]                  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx        <= '0;
            asm_data   <= '0;
            asm_keep   <= '0;
            words_sent <= '0;
        end else begin
            if (accept) begin
                if (close) begin
                    idx      <= '0;
                    asm_data <= '0;
                    asm_keep <= '0;
                end else begin
                    idx      <= idx + 1'b1;
                    asm_data <= word_d;
                    asm_keep <= keep_d;
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                words_sent <= words_sent + 1'b1;
            end
        end
    end

    hd_out_reg #(
        .W (DATA_W*LANES),
        .K (LANES)
    ) u_out_reg (
        .clk         (clk),
        .rst         (rst),
        .load        (close),
        .load_data   (word_d),
        .load_keep   (keep_d),
        .load_last   (bus.in_last),
        .drain_ready (bus.out_ready),
        .out_valid   (bus.out_valid),
        .out_data    (bus.out_data),
        .out_keep    (bus.out_keep),
        .out_last    (bus.out_last)
    );

endmodule

// File: tb/tb_hd_result_packer.sv
// Directed bench for hd_result_packer with hand-computed expected words.
// Latency: checks out_valid exactly one cycle after each closing handshake.
// Backpressure: exercises stalled output, drain, reset mid-word and counter wrap.
module tb_hd_result_packer import hd_pkg::*;;

    logic        clk;
    logic        rst;
    logic [15:0] words_sent;

    hd_result_packer_if bus ();

    hd_result_packer dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .words_sent (words_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one result and hold it until accepted (bounded wait).
    task automatic send(input hd_word_t d, input logic last);
        int guard;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        #1;
        guard = 0;
        while (!bus.in_ready && guard < 100) begin
            step();
            guard++;
        end
        if (guard >= 100) chk("send_timeout", 32'(guard), 32'd0);
        step();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    hd_packed_t held;
    hd_packed_t got_q[$];

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        step();
        step();
        rst = 1'b0;

        // Reset state
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data",  bus.out_data,       32'h0);
        chk("rst_out_keep",  32'(bus.out_keep),  32'h0);
        chk("rst_out_last",  32'(bus.out_last),  32'd0);
        chk("rst_words",     32'(words_sent),    32'd0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);

        // Full word, one-cycle latency
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h03, 1'b0);
        chk("w1_not_early", 32'(bus.out_valid), 32'd0);
        send(8'h04, 1'b0);
        chk("w1_valid", 32'(bus.out_valid), 32'd1);
        chk("w1_data",  bus.out_data,       32'h04030201);
        chk("w1_keep",  32'(bus.out_keep),  32'hF);
        chk("w1_last",  32'(bus.out_last),  32'd0);
        step();
        chk("w1_drained", 32'(bus.out_valid), 32'd0);
        chk("w1_words",   32'(words_sent),    32'd1);

        // Early close by in_last
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b1);
        chk("w2_data", bus.out_data,      32'h0000BBAA);
        chk("w2_keep", 32'(bus.out_keep), 32'h3);
        chk("w2_last", 32'(bus.out_last), 32'd1);
        step();
        chk("w2_words", 32'(words_sent), 32'd2);

        // Backpressure: word held for 10 cycles, extra input ignored
        bus.out_ready = 1'b0;
        send(8'h10, 1'b0);
        send(8'h11, 1'b0);
        send(8'h12, 1'b0);
        send(8'h13, 1'b0);
        held = bus.out_data;
        chk("bp_data", held, 32'h13121110);
        chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.in_data = 8'(8'hE0 + i);
            bus.in_last = i[0];
            step();
            chk("bp_stable", bus.out_data, held);
        end
        chk("bp_valid_held", 32'(bus.out_valid), 32'd1);
        chk("bp_words_held", 32'(words_sent),    32'd2);
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        step();
        chk("bp_drain_words", 32'(words_sent),    32'd3);
        chk("bp_drain_valid", 32'(bus.out_valid), 32'd0);
        step();
        chk("bp_once_words", 32'(words_sent), 32'd3);

        // Continuous stream of 12 results, no bubbles
        bus.in_valid = 1'b1;
        bus.in_last  = 1'b0;
        for (int i = 0; i < 12; i++) begin
            bus.in_data = 8'(i + 1);
            #1;
            chk("st_in_ready", 32'(bus.in_ready), 32'd1);
            step();
            if (bus.out_valid) got_q.push_back(bus.out_data);
        end
        bus.in_valid = 1'b0;
        step();
        chk("st_count", 32'(got_q.size()), 32'd3);
        if (got_q.size() == 3) begin
            chk("st_w0", got_q[0], 32'h04030201);
            chk("st_w1", got_q[1], 32'h08070605);
            chk("st_w2", got_q[2], 32'h0C0B0A09);
        end
        chk("st_words", 32'(words_sent), 32'd6);

        // in_last on the last lane: full keep with last set
        send(8'hC1, 1'b0);
        send(8'hC2, 1'b0);
        send(8'hC3, 1'b0);
        send(8'hC4, 1'b1);
        chk("fl_data", bus.out_data,      32'hC4C3C2C1);
        chk("fl_keep", 32'(bus.out_keep), 32'hF);
        chk("fl_last", 32'(bus.out_last), 32'd1);
        step();
        chk("fl_words", 32'(words_sent), 32'd7);

        // Reset mid-word discards partial assembly
        send(8'h55, 1'b0);
        send(8'h66, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mr_words", 32'(words_sent),    32'd0);
        chk("mr_valid", 32'(bus.out_valid), 32'd0);
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        send(8'h44, 1'b0);
        chk("mr_data",        bus.out_data,   32'h44332211);
        chk("mr_words_pre",   32'(words_sent), 32'd0);
        step();
        chk("mr_words_post",  32'(words_sent), 32'd1);

        // Single-lane words one per cycle until the counter reads FFFF
        bus.in_valid = 1'b1;
        bus.in_last  = 1'b1;
        bus.in_data  = 8'h5A;
        step();
        chk("sl_data", bus.out_data,      32'h0000005A);
        chk("sl_keep", 32'(bus.out_keep), 32'h1);
        chk("sl_last", 32'(bus.out_last), 32'd1);
        for (int i = 1; i < 65534; i++) step();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        step();
        chk("wr_pre", 32'(words_sent), 32'hFFFF);
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h03, 1'b0);
        send(8'h04, 1'b0);
        step();
        chk("wr_wrap", 32'(words_sent), 32'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
